// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding and the requester-index width rule.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and UART-side byte handshakes of the transmit arbiter.
// The arbiter uses the slave view; the surrounding producers and UART core use master.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned BITS_PER_WORD = 8
);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*BITS_PER_WORD-1:0] req_data;
  logic [NUM_REQ-1:0]               req_last;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             m_valid;
  logic [BITS_PER_WORD-1:0]         m_data;
  logic                             m_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational circular first-one search: the first set bit of req at or
// after ptr, wrapping past N-1 back to 0.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W:0] cand;

  // One extra bit holds ptr+k before the explicit wrap, so N need not be a power of two.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (W+1)'(k);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (!found && req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter with packet locking and a lock watchdog, feeding
// a single-register output slot into the UART core transmit input.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned BITS_PER_WORD = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         rstn,
  uart_tx_arbiter_if.slave             bus,
  output logic [id_width(NUM_REQ)-1:0] grant_id,
  output logic                         locked,
  output logic                         timeout_err
);

  localparam int unsigned IW = id_width(NUM_REQ);
  localparam int unsigned WW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e               state, state_nx;
  logic [IW-1:0]            ptr, ptr_nx;
  logic [IW-1:0]            owner, owner_nx;
  logic [IW-1:0]            grant_nx;
  logic [IW-1:0]            rr_idx, pick;
  logic                     rr_found, pick_ok;
  logic                     slot_free, accept, acc_last;
  logic [BITS_PER_WORD-1:0] acc_data;
  logic [NUM_REQ-1:0]       ready;
  logic [WW-1:0]            wdog, wdog_nx;
  logic                     tout_nx;
  logic                     m_valid_q, m_valid_nx;
  logic [BITS_PER_WORD-1:0] m_data_q, m_data_nx;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    if (id == IW'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Nothing is offered while reset is held, so req_ready reads 0 during reset.
  always_comb begin
    slot_free = !m_valid_q || bus.m_ready;
    pick      = (state == ARB_LOCKED) ? owner : rr_idx;
    pick_ok   = (state == ARB_LOCKED) ? bus.req_valid[owner] : rr_found;
    accept    = rstn && slot_free && pick_ok;
    acc_data  = '0;
    acc_last  = 1'b0;
    ready     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) begin
        acc_data = bus.req_data[i*BITS_PER_WORD +: BITS_PER_WORD];
        acc_last = bus.req_last[i];
        ready[i] = accept;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    owner_nx   = owner;
    wdog_nx    = wdog;
    tout_nx    = 1'b0;
    grant_nx   = grant_id;
    m_valid_nx = m_valid_q;
    m_data_nx  = m_data_q;
    if (accept) begin
      m_valid_nx = 1'b1;
      m_data_nx  = acc_data;
      grant_nx   = pick;
      wdog_nx    = '0;
      if (acc_last) begin
        state_nx = ARB_IDLE;
        ptr_nx   = next_id(pick);
      end else begin
        state_nx = ARB_LOCKED;
        owner_nx = pick;
      end
    end else begin
      if (bus.m_ready) begin
        m_valid_nx = 1'b0;
      end
      // Only an owner with nothing to offer ages the lock; back-pressure never does.
      if (state == ARB_LOCKED && !bus.req_valid[owner]) begin
        if (wdog == WW'(LOCK_TIMEOUT - 1)) begin
          state_nx = ARB_IDLE;
          ptr_nx   = next_id(owner);
          wdog_nx  = '0;
          tout_nx  = 1'b1;
        end else begin
          wdog_nx = wdog + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      owner       <= '0;
      wdog        <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      owner       <= owner_nx;
      wdog        <= wdog_nx;
      grant_id    <= grant_nx;
      timeout_err <= tout_nx;
      m_valid_q   <= m_valid_nx;
      m_data_q    <= m_data_nx;
    end
  end

  assign bus.req_ready = ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign locked        = (state == ARB_LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued producers per requester, an
// output log of UART-side transfers, and hand-computed expectations.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] grant_id;
  logic       locked;
  logic       timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(3), .BITS_PER_WORD(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (3),
    .BITS_PER_WORD (8),
    .LOCK_TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .grant_id    (grant_id),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [8:0]  pmem [3][16];
  int unsigned ph [3];
  int unsigned pt [3];
  logic        mrdy;
  logic [7:0]  obs [$];
  int          obs_cyc [$];
  int          cyc;
  logic        lk_h [0:1023];
  logic        to_h [0:1023];
  int          acc_at [3];
  int          multi_rdy;
  logic        watch_r2;
  int          r2_bad;
  logic [2:0]  snap_rdy;
  logic        snap_mv;
  logic [7:0]  snap_md;

  task automatic push(input int i, input logic last, input logic [7:0] d);
    pmem[i][pt[i] % 16] = {last, d};
    pt[i]++;
  endtask

  function automatic logic [31:0] obs_at(input int k);
    if (k < obs.size()) return {24'b0, obs[k]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int k);
    if (k < obs_cyc.size()) return obs_cyc[k];
    return -1000;
  endfunction

  task automatic zero_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.m_ready   = mrdy;
  endtask

  // One clock: drive queue heads, sample just after, pop accepted bytes after the edge.
  task automatic cycle();
    logic [2:0]  v, l, fire;
    logic [23:0] d;
    logic [8:0]  e;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < 3; i++) begin
      if (ph[i] != pt[i]) begin
        e = pmem[i][ph[i] % 16];
        v[i] = 1'b1;
        l[i] = e[8];
        d[i*8 +: 8] = e[7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.m_ready   = mrdy;
    #1;
    snap_rdy = bus.req_ready;
    snap_mv  = bus.m_valid;
    snap_md  = bus.m_data;
    if (cyc < 1024) begin
      lk_h[cyc] = locked;
      to_h[cyc] = timeout_err;
    end
    if (snap_mv && mrdy) begin
      obs.push_back(snap_md);
      obs_cyc.push_back(cyc);
    end
    if ($countones(snap_rdy) > 1) multi_rdy++;
    if (watch_r2 && snap_rdy[2] && ph[0] != pt[0]) r2_bad++;
    fire = v & snap_rdy;
    for (int i = 0; i < 3; i++) if (fire[i]) acc_at[i] = cyc;
    @(posedge clk);
    for (int i = 0; i < 3; i++) if (fire[i]) ph[i]++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    mrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0;
      pt[i] = 0;
      acc_at[i] = -1;
    end
    obs.delete();
    obs_cyc.delete();
    zero_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic int count_hist(input int lo, input int hi, input logic which);
    int n = 0;
    for (int c = lo; c <= hi; c++) begin
      if (which ? to_h[c] : lk_h[c]) n++;
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int s2;
    int gaps;
    int hold_bad;
    logic [7:0] pat [3];
    pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2;
    cyc = 0; multi_rdy = 0; watch_r2 = 1'b0; r2_bad = 0;
    for (int c = 0; c < 1024; c++) begin lk_h[c] = 1'b0; to_h[c] = 1'b0; end
    rstn = 1'b0;
    mrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin ph[i] = 0; pt[i] = 0; acc_at[i] = -1; end
    zero_inputs();

    // Reset values, with every requester asking during reset
    @(negedge clk);
    bus.req_valid = '1;
    bus.req_last  = '1;
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout_err", timeout_err, 0);
    zero_inputs();
    @(negedge clk);
    rstn = 1'b1;

    // Single byte from requester 1
    s = cyc;
    push(1, 1'b1, 8'h44);
    repeat (4) cycle();
    check("t1_count", obs.size(), 1);
    check("t1_data", obs_at(0), 32'h44);
    check("t1_latency", cyc_at(0) - acc_at[1], 1);
    check("t1_grant_id", grant_id, 1);
    check("t1_never_locked", count_hist(s, cyc - 1, 1'b0), 0);

    // Three requesters streaming single bytes
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push(0, 1'b1, 8'hA0);
      push(1, 1'b1, 8'hB1);
      push(2, 1'b1, 8'hC2);
    end
    repeat (14) cycle();
    check("t2_count", obs.size(), 12);
    for (int k = 0; k < 12; k++) check($sformatf("t2_byte%0d", k), obs_at(k), {24'b0, pat[k % 3]});
    gaps = 0;
    for (int k = 0; k + 1 < obs_cyc.size(); k++) if (obs_cyc[k+1] != obs_cyc[k] + 1) gaps++;
    check("t2_gaps", gaps, 0);

    // Locked 3-byte packet from 0 while 2 waits
    do_reset();
    s = cyc;
    push(0, 1'b0, 8'h11);
    push(0, 1'b0, 8'h22);
    push(0, 1'b1, 8'h33);
    push(2, 1'b1, 8'h99);
    watch_r2 = 1'b1;
    r2_bad = 0;
    repeat (8) cycle();
    watch_r2 = 1'b0;
    check("t3_b0", obs_at(0), 32'h11);
    check("t3_b1", obs_at(1), 32'h22);
    check("t3_b2", obs_at(2), 32'h33);
    check("t3_b3", obs_at(3), 32'h99);
    check("t3_r2_early_ready", r2_bad, 0);
    check("t3_r2_accept_cycle", acc_at[2] - s, 3);
    check("t3_locked_high", lk_h[s+1], 1);
    check("t3_locked_low", lk_h[s+3], 0);

    // Back-pressure holds the slot stable
    do_reset();
    s = cyc;
    mrdy = 1'b0;
    push(0, 1'b1, 8'h55);
    push(1, 1'b1, 8'h66);
    cycle();
    hold_bad = 0;
    repeat (20) begin
      cycle();
      if (!snap_mv || snap_md !== 8'h55 || snap_rdy !== 3'b000) hold_bad++;
    end
    mrdy = 1'b1;
    repeat (3) cycle();
    check("t4_first_accept", acc_at[0] - s, 0);
    check("t4_hold", hold_bad, 0);
    check("t4_b0", obs_at(0), 32'h55);
    check("t4_b1", obs_at(1), 32'h66);
    check("t4_release_cycle", cyc_at(0) - s, 21);
    check("t4_follow_gap", cyc_at(1) - cyc_at(0), 1);

    // Watchdog breaks a stalled lock
    do_reset();
    s = cyc;
    push(1, 1'b0, 8'h10);
    cycle();
    push(0, 1'b1, 8'h77);
    repeat (12) cycle();
    check("t5_lock_accept", acc_at[1] - s, 0);
    check("t5_pulse_count", count_hist(s, s + 12, 1'b1), 1);
    check("t5_pulse_cycle", to_h[s+9], 1);
    check("t5_locked_before", lk_h[s+8], 1);
    check("t5_locked_after", lk_h[s+9], 0);
    check("t5_r0_accept_cycle", acc_at[0] - s, 9);
    check("t5_b0", obs_at(0), 32'h10);
    check("t5_b1", obs_at(1), 32'h77);
    check("t5_grant_id", grant_id, 0);

    // Asynchronous reset mid-packet, then round-robin restarts at 0
    do_reset();
    push(1, 1'b1, 8'h5A);
    repeat (2) cycle();
    mrdy = 1'b0;
    push(1, 1'b0, 8'hAB);
    push(1, 1'b1, 8'hCD);
    repeat (2) cycle();
    check("t6_pre_m_valid", bus.m_valid, 1);
    check("t6_pre_locked", locked, 1);
    check("t6_pre_grant_id", grant_id, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_m_valid", bus.m_valid, 0);
    check("t6_m_data", bus.m_data, 0);
    check("t6_req_ready", bus.req_ready, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_locked", locked, 0);
    check("t6_timeout_err", timeout_err, 0);
    for (int i = 0; i < 3; i++) begin ph[i] = 0; pt[i] = 0; acc_at[i] = -1; end
    obs.delete();
    obs_cyc.delete();
    @(negedge clk);
    rstn = 1'b1;
    mrdy = 1'b1;
    push(2, 1'b1, 8'hC2);
    push(1, 1'b1, 8'hB1);
    push(0, 1'b1, 8'hA0);
    s2 = cyc;
    repeat (5) cycle();
    check("t6_first_accept", acc_at[0] - s2, 0);
    check("t6_b0", obs_at(0), 32'hA0);
    check("t6_b1", obs_at(1), 32'hB1);
    check("t6_b2", obs_at(2), 32'hC2);

    check("onehot_ready", multi_rdy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit stream among NUM_REQ independent byte producers, such as detection notifier, mode-change reporter and RX echo. It uses round-robin arbitration with packet locking, so multi-byte messages are never interleaved. It sits between the producers and the UART core's transmit input (s_valid/s_data/s_ready) inside the transceiver top. A lock watchdog prevents a stalled producer from holding the link forever.

## Interface
- NUM_REQ, default 3: number of requesters, 2..8.
- BITS_PER_WORD, default 8: byte width; matches the UART core.
- LOCK_TIMEOUT, default 1024: idle cycles tolerated mid-packet before the lock is broken. Must be ≥1.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*BITS_PER_WORD  flattened bytes; requester i occupies bits [i*BITS_PER_WORD +: BITS_PER_WORD].
- req_last  in  NUM_REQ  byte is the final byte of its packet. Single-byte messages set it high.
- req_ready  out  NUM_REQ  per-requester accept.
- m_valid  out  1  to UART s_valid.
- m_data  out  BITS_PER_WORD  to UART s_data.
- m_ready  in  1  from UART s_ready.
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current/last grant.
- locked  out  1  a packet is in progress.
- timeout_err  out  1  one-cycle pulse when the watchdog breaks a lock.

## Operation
- Transfer rule, both sides: a transfer occurs at the rising edge where valid && ready.
  - Producers hold valid, data and last stable until accepted.
  - m_valid, once high, stays high with m_data stable until m_ready.
- Output slot: a single register stage.
  - slot_free = !m_valid || m_ready.
  - Loading and draining in the same cycle is legal, giving one byte/cycle throughput.
- Selection: pick one requester per cycle.
  - req_ready[i] = slot_free && (i == pick) && req_valid[i]. At most one bit is high.
  - req_ready is combinational from m_ready and req_valid.
- FSM, two states:
  - IDLE: pick = first i with req_valid[i], searching circularly from ptr.
    - Accepting a byte with last=0 → LOCKED, owner=i.
    - Accepting a byte with last=1 → stay in IDLE.
  - LOCKED: pick = owner only; all other requesters see ready=0.
    - Accepting an owner byte with last=1 → IDLE.
    - Watchdog expiry → IDLE and timeout_err pulse.
- Round-robin pointer:
  - Updates only when a packet completes (a last=1 byte is accepted), or on timeout.
  - New value: ptr ← owner+1 mod NUM_REQ.
  - Lock-free single-byte grants also advance ptr the same way.
- Watchdog:
  - Counter clears on every owner accept and on entry to LOCKED.
  - It increments each LOCKED cycle with req_valid[owner]=0.
  - Reaching LOCK_TIMEOUT triggers release.
  - A byte already in the output slot is still delivered.
- grant_id updates on each accept and holds otherwise.
- Reset values:
  - m_valid=0, m_data=0, req_ready=0.
  - grant_id=0, locked=0, timeout_err=0.
  - State IDLE, ptr=0, watchdog=0.
- Reset mid-packet drops the in-flight byte and the lock immediately. No partial byte survives.

## Timing
- Accept at edge N → m_valid high from N+1 (one-cycle latency). Zero bubbles while m_ready=1.
- locked reflects the FSM register: high the cycle after a last=0 accept, low the cycle after the last=1 accept or timeout.
- Simultaneous owner accept and watchdog reaching its limit: the accept wins and the counter clears.
- With m_ready held low, no accepts occur and the watchdog keeps counting only if the owner is idle. A producer that is merely back-pressured is never timed out.
- NUM_REQ not a power of two: the ptr wrap uses explicit compare, never a bit truncation.

## Structure
- Package uart_arb_pkg holds:
  - arb_state_e {ARB_IDLE, ARB_LOCKED};
  - the function for the id width, clog2 of NUM_REQ with a minimum of 1.
- Sub-module rr_pick: purely combinational circular first-one search.
  - Inputs: req vector, ptr.
  - Outputs: index and found flag.
  - Reused for both the IDLE search and future arbiters.
- Top holds the output register, FSM, ptr, owner and watchdog.

## Test plan
- Single requester 1 sends 0x44 last=1, m_ready=1 → m_data=0x44 one cycle after the accept; grant_id=1, locked never asserts.
- Requesters 0,1,2 each hold valid with single-byte messages 0xA0/0xB1/0xC2 continuously, m_ready=1 → output sequence A0,B1,C2,A0,… with no gaps and no starvation.
- Requester 0 sends the 3-byte packet 0x11,0x22,0x33 (last on 0x33) while requester 2 requests 0x99 → output 11,22,33,99; req_ready[2]=0 until the 0x33 accept.
- m_ready low for 20 cycles with m_valid=1, m_data=0x55 → data held stable, no req_ready high, then 0x55 transfers and the next byte follows the cycle after.
- LOCK_TIMEOUT=8: requester 1 sends 0x10 last=0, then drops valid → timeout_err pulses exactly 8 idle cycles later, locked falls, and requester 0's pending 0x77 is granted next.
- Assert rstn low mid-packet with m_valid=1 → all outputs return to their reset values asynchronously; after release, the first grant starts from requester 0.
